adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_pkg.sv | 22 ++
 rtl/adc_chan_picker.sv | 42 ++++
 rtl/adc_scan_sequencer.sv | 168 ++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : adc_pkg
// Brief   : Shared widths and scan state encoding for the ADC scan sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package adc_pkg;

    localparam int NUM_CHAN = 8;
    localparam int ADC_W    = 12;
    localparam int CHAN_W   = 3;
    localparam int DWELL_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SELECT  = 2'd1,
        S_DWELL   = 2'd2,
        S_CAPTURE = 2'd3
    } scan_state_t;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_chan_picker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : adc_chan_picker
// Brief   : Finds the lowest set mask bit above cur; wraps to the lowest set bit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module adc_chan_picker
    import adc_pkg::*;
(
    input  logic [NUM_CHAN-1:0] mask,
    input  logic [CHAN_W-1:0]   cur,
    output logic [CHAN_W-1:0]   next_chan,
    output logic                wrap,
    output logic                empty
);

    logic [CHAN_W-1:0] w_lowest;
    logic [CHAN_W-1:0] w_above;
    logic              w_found;

    // Descending scan so the last hit written is the lowest qualifying bit.
    always_comb begin
        w_lowest = '0;
        w_above  = '0;
        w_found  = 1'b0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                w_lowest = CHAN_W'(i);
                if (CHAN_W'(i) > cur) begin
                    w_above = CHAN_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign empty     = (mask == '0);
    assign wrap      = ~w_found;
    assign next_chan = w_found ? w_above : w_lowest;

endmodule : adc_chan_picker
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : adc_scan_sequencer
// Brief   : Round-robin ADC channel scanner with dwell timing and result bank.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int DWELL_CYCLES = 48
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_CHAN-1:0] chan_mask,
    input  logic [ADC_W-1:0]    adc_result,
    output logic [CHAN_W-1:0]   adc_chan,
    output logic                sample_valid,
    output logic [CHAN_W-1:0]   sample_chan,
    output logic [ADC_W-1:0]    sample_data,
    output logic                scan_done,
    output logic                busy,
    input  logic [CHAN_W-1:0]   rd_chan,
    output logic [ADC_W-1:0]    rd_data
);

    localparam logic [DWELL_W-1:0] c_dwell_load = DWELL_W'(DWELL_CYCLES - 1);

    scan_state_t         r_state;
    scan_state_t         w_next_state;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [NUM_CHAN-1:0] r_scan_mask;
    logic [CHAN_W-1:0]   r_adc_chan;
    logic                r_sample_valid;
    logic                r_scan_done;
    logic [CHAN_W-1:0]   r_sample_chan;
    logic [ADC_W-1:0]    r_sample_data;
    logic [ADC_W-1:0]    r_bank [NUM_CHAN];

    logic [CHAN_W-1:0]   w_above;
    logic                w_scan_wrap;
    logic                w_scan_empty;
    logic                w_scan_end;
    logic [CHAN_W-1:0]   w_new_lowest;
    logic                w_new_wrap;
    logic                w_new_empty;
    logic                w_new_avail;

    adc_chan_picker u_scan_pick (
        .mask      (r_scan_mask),
        .cur       (r_adc_chan),
        .next_chan (w_above),
        .wrap      (w_scan_wrap),
        .empty     (w_scan_empty)
    );

    // Searching from the top index always wraps, yielding the lowest set bit.
    adc_chan_picker u_new_pick (
        .mask      (chan_mask),
        .cur       (CHAN_W'(NUM_CHAN - 1)),
        .next_chan (w_new_lowest),
        .wrap      (w_new_wrap),
        .empty     (w_new_empty)
    );

    assign w_scan_end  = w_scan_wrap | w_scan_empty;
    assign w_new_avail = w_new_wrap & ~w_new_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && w_new_avail) begin
                    w_next_state = S_SELECT;
                end
            end
            S_SELECT: begin
                w_next_state = S_DWELL;
            end
            S_DWELL: begin
                if (r_dwell_cnt == '0) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!enable || (w_scan_end && !w_new_avail)) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_SELECT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell_cnt    <= '0;
            r_scan_mask    <= '0;
            r_adc_chan     <= '0;
            r_sample_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            r_sample_chan  <= '0;
            r_sample_data  <= '0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            r_sample_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && w_new_avail) begin
                        r_scan_mask <= chan_mask;
                        r_adc_chan  <= w_new_lowest;
                    end
                end
                S_SELECT: begin
                    r_dwell_cnt <= c_dwell_load;
                end
                S_DWELL: begin
                    if (r_dwell_cnt != '0) begin
                        r_dwell_cnt <= r_dwell_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_bank[r_adc_chan] <= adc_result;
                    r_sample_data      <= adc_result;
                    r_sample_chan      <= r_adc_chan;
                    r_sample_valid     <= 1'b1;
                    r_scan_done        <= w_scan_end;
                    // New masks are only honoured at the scan boundary.
                    if (w_scan_end) begin
                        r_scan_mask <= chan_mask;
                        if (w_new_avail) begin
                            r_adc_chan <= w_new_lowest;
                        end
                    end else begin
                        r_adc_chan <= w_above;
                    end
                end
                default: begin
                    r_dwell_cnt <= '0;
                end
            endcase
        end
    end

    assign adc_chan     = r_adc_chan;
    assign sample_valid = r_sample_valid;
    assign sample_chan  = r_sample_chan;
    assign sample_data  = r_sample_data;
    assign scan_done    = r_scan_done;
    assign busy         = (r_state != S_IDLE);
    assign rd_data      = r_bank[rd_chan];

endmodule : adc_scan_sequencer
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_adc_scan_sequencer
// Brief   : Self-checking bench: vector table plus scoreboard of expected samples.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_adc_scan_sequencer;
    import adc_pkg::*;

    localparam int DW  = 48;
    localparam int PER = DW + 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [7:0]        chan_mask = '0;
    logic [11:0]       base = '0;
    logic              xorch = 1'b0;
    logic [11:0]       adc_result;
    logic [2:0]        rd_chan = '0;
    logic [2:0]        adc_chan;
    logic              sample_valid;
    logic [2:0]        sample_chan;
    logic [11:0]       sample_data;
    logic              scan_done;
    logic              busy;
    logic [11:0]       rd_data;

    adc_scan_sequencer #(.DWELL_CYCLES(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .chan_mask    (chan_mask),
        .adc_result   (adc_result),
        .adc_chan     (adc_chan),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .scan_done    (scan_done),
        .busy         (busy),
        .rd_chan      (rd_chan),
        .rd_data      (rd_data)
    );

    // Optional per-channel tag in bits [11:9] makes bank entries distinguishable.
    assign adc_result = xorch ? (base ^ {adc_chan, 9'b0}) : base;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  chan;
        logic [11:0] data;
        logic        done;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  mask;
        logic [11:0] base;
        logic        xorch;
        int          n;
        logic [2:0]  exp_first;
    } vec_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] chan_data(logic [11:0] b, logic x, int ch);
        logic [2:0] c;
        c = 3'(ch);
        return x ? (b ^ {c, 9'b0}) : b;
    endfunction

    // Reference scan: ascending set bits, repeating; scan_done on the highest bit.
    task automatic push_scan(logic [7:0] m, logic [11:0] b, logic x, int n, int c0);
        exp_t r;
        int   k = 0;
        int   ch = 0;
        int   hi = 0;
        for (int i = 0; i < 8; i++) if (m[i]) hi = i;
        while (k < n) begin
            if (m[ch]) begin
                r.chan = 3'(ch);
                r.data = chan_data(b, x, ch);
                r.done = (ch == hi);
                r.cyc  = c0 + PER * (k + 1);
                q.push_back(r);
                k++;
            end
            ch = (ch + 1) % 8;
        end
    endtask

    task automatic push_one(int ch, logic [11:0] d, logic dn, int c);
        exp_t r;
        r.chan = 3'(ch);
        r.data = d;
        r.done = dn;
        r.cyc  = c;
        q.push_back(r);
    endtask

    task automatic wait_size(int target, int budget);
        int t = 0;
        while (q.size() > target && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > target) begin
            check("scoreboard_timeout", q.size(), target);
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && scan_done && !sample_valid)
            check("scan_done_without_valid", 1, 0);
        if (reset_n && sample_valid) begin
            if (q.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                e = q.pop_front();
                check("sample_chan",  sample_chan, e.chan);
                check("sample_data",  sample_data, e.data);
                check("scan_done",    scan_done,   e.done);
                check("sample_cycle", cyc,         e.cyc);
            end
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_adc_chan"},     adc_chan,     0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_scan_done"},    scan_done,    0);
        check({tag, "_sample_chan"},  sample_chan,  0);
        check({tag, "_sample_data"},  sample_data,  0);
        check({tag, "_busy"},         busy,         0);
        for (int i = 0; i < 8; i++) begin
            rd_chan = 3'(i);
            #1;
            check({tag, "_bank"}, rd_data, 0);
        end
    endtask

    initial begin
        static vec_t tbl[5];
        int c0;
        int nbusy;
        tbl[0] = '{mask: 8'h05, base: 12'hA5A, xorch: 1'b0, n: 2, exp_first: 3'd0};
        tbl[1] = '{mask: 8'h80, base: 12'h123, xorch: 1'b1, n: 3, exp_first: 3'd7};
        tbl[2] = '{mask: 8'hFF, base: 12'h0F0, xorch: 1'b1, n: 9, exp_first: 3'd0};
        tbl[3] = '{mask: 8'h5A, base: 12'h3C3, xorch: 1'b1, n: 5, exp_first: 3'd1};
        tbl[4] = '{mask: 8'h00, base: 12'h777, xorch: 1'b0, n: 0, exp_first: 3'd0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            chan_mask = tbl[v].mask;
            base      = tbl[v].base;
            xorch     = tbl[v].xorch;
            enable    = 1'b1;
            c0        = cyc + 1;
            if (tbl[v].n == 0) begin
                nbusy = 0;
                repeat (120) begin
                    @(negedge clk);
                    if (busy !== 1'b0) nbusy++;
                end
                check("mask0_busy_cycles", nbusy, 0);
                enable = 1'b0;
            end else begin
                push_scan(tbl[v].mask, tbl[v].base, tbl[v].xorch, tbl[v].n, c0);
                @(negedge clk);
                check("first_adc_chan", adc_chan, tbl[v].exp_first);
                check("busy_in_scan", busy, 1);
                wait_size(1, PER * tbl[v].n + 20);
                enable = 1'b0;
                wait_size(0, PER + 20);
                repeat (2) @(negedge clk);
                check("idle_after_scan", busy, 0);
                for (int ch = 0; ch < 8; ch++) begin
                    if (tbl[v].mask[ch]) begin
                        rd_chan = 3'(ch);
                        #1;
                        check("bank_readback", rd_data,
                              chan_data(tbl[v].base, tbl[v].xorch, ch));
                    end
                end
            end
        end

        // Mask change mid-scan only takes effect at the wrap.
        @(negedge clk);
        chan_mask = 8'h03;
        base      = 12'h2B4;
        xorch     = 1'b0;
        enable    = 1'b1;
        c0        = cyc + 1;
        push_one(0, 12'h2B4, 1'b0, c0 + PER);
        push_one(1, 12'h2B4, 1'b1, c0 + 2 * PER);
        push_one(4, 12'h2B4, 1'b1, c0 + 3 * PER);
        repeat (10) @(negedge clk);
        chan_mask = 8'h10;
        wait_size(1, 2 * PER + 20);
        check("chan_after_mask_change", adc_chan, 4);
        enable = 1'b0;
        wait_size(0, PER + 20);
        repeat (2) @(negedge clk);
        check("idle_after_mask_change", busy, 0);

        // Enable dropped during dwell: that channel finishes, then idle.
        @(negedge clk);
        chan_mask = 8'h18;
        base      = 12'h5C5;
        enable    = 1'b1;
        c0        = cyc + 1;
        push_one(3, 12'h5C5, 1'b0, c0 + PER);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_size(0, PER + 20);
        check("busy_at_last_sample", busy, 0);
        repeat (100) @(negedge clk);
        check("still_idle_after_drop", busy, 0);
        rd_chan = 3'd3;
        #1;
        check("bank3_after_drop", rd_data, 12'h5C5);

        // Asynchronous reset mid-dwell clears everything and kills the capture.
        @(negedge clk);
        chan_mask = 8'h01;
        base      = 12'h111;
        enable    = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_after_reset", busy, 0);
        check("scoreboard_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule : tb_adc_scan_sequencer
`default_nettype wire
